// File: rtl/mem_1rw_pkg.sv
// Shared definitions for blocks that front the 16x4 single-port mem_1rw.
//   MEM_WIDTH / MEM_ADDR_W / MEM_NUM_REQ : default word width, address width, requester count
//   mem_cmd_t                            : one memory command {w, addr, data} at default widths
package mem_1rw_pkg;
  localparam int MEM_WIDTH   = 4;
  localparam int MEM_ADDR_W  = 4;
  localparam int MEM_NUM_REQ = 2;

  typedef struct packed {
    logic                  w;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_WIDTH-1:0]  data;
  } mem_cmd_t;
endpackage

// File: rtl/mem_1rw_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of mem_1rw_arbiter.
//   slave  : arbiter view (takes requests and mem read data, drives yumi/resp/mem cmd)
//   master : environment view (requesters plus the memory instance)
// Requester k owns element k of each packed per-requester array.
interface mem_1rw_arbiter_if
  import mem_1rw_pkg::*;
#(
  parameter int width_p      = MEM_WIDTH,
  parameter int addr_width_p = MEM_ADDR_W,
  parameter int num_req_p    = MEM_NUM_REQ
);
  logic [num_req_p-1:0]                   req_v_i;
  logic [num_req_p-1:0]                   req_w_i;
  logic [num_req_p-1:0][addr_width_p-1:0] req_addr_i;
  logic [num_req_p-1:0][width_p-1:0]      req_data_i;
  logic [num_req_p-1:0]                   req_yumi_o;
  logic [num_req_p-1:0]                   resp_v_o;
  logic [width_p-1:0]                     resp_data_o;
  logic                                   mem_v_o;
  logic                                   mem_w_o;
  logic [addr_width_p-1:0]                mem_addr_o;
  logic [width_p-1:0]                     mem_data_o;
  logic [width_p-1:0]                     mem_data_i;

  modport slave (
    input  req_v_i, req_w_i, req_addr_i, req_data_i, mem_data_i,
    output req_yumi_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_v_i, req_w_i, req_addr_i, req_data_i, mem_data_i,
    input  req_yumi_o, resp_v_o, resp_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_1rw_arbiter_rr_arb.sv
// Round-robin grant: purely combinational.
//   req_i      : request vector
//   last_i     : index of the previous winner; priority starts at last_i+1 and wraps
//   grant_o    : one-hot grant (zero when no request)
//   grant_id_o : index of the granted requester (0 when no grant)
//   grant_v_o  : any grant this cycle
module rr_arb #(
  parameter int num_req_p = 2,
  parameter int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [id_w_lp-1:0]   last_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [id_w_lp-1:0]   grant_id_o,
  output logic                 grant_v_o
);
  logic found;

  // Walk offsets 1..N from last_i; the first requesting slot wins.
  // Offset N lands back on last_i, so a lone repeat requester still wins.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    for (int off = 1; off <= num_req_p; off++) begin
      for (int i = 0; i < num_req_p; i++) begin
        if (!found && req_i[i] && (((int'(last_i) + off) % num_req_p) == i)) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          grant_id_o = id_w_lp'(i);
        end
      end
    end
  end

  assign grant_v_o = |grant_o;
endmodule

// File: rtl/mem_1rw_arbiter.sv
// Shares one single-port 1RW memory between num_req_p requesters.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (slave)    : requester valid/yumi commands, per-requester read responses,
//                    and the command/read-data pins of the external memory
// At most one command reaches the memory per cycle; read data comes back one
// cycle after the grant on the shared resp_data_o, tagged by one-hot resp_v_o.
module mem_1rw_arbiter
  import mem_1rw_pkg::*;
#(
  parameter int width_p      = MEM_WIDTH,
  parameter int addr_width_p = MEM_ADDR_W,
  parameter int num_req_p    = MEM_NUM_REQ
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_1rw_arbiter_if.slave  bus
);
  localparam int id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef struct packed {
    logic                    w;
    logic [addr_width_p-1:0] addr;
    logic [width_p-1:0]      data;
  } cmd_t;

  logic [num_req_p-1:0] req_ok;
  logic [num_req_p-1:0] grant;
  logic [id_w_lp-1:0]   grant_id;
  logic                 grant_v;
  cmd_t                 sel_cmd;

  logic [id_w_lp-1:0]   last_d, last_q;
  logic                 pend_v_d, pend_v_q;
  logic [id_w_lp-1:0]   pend_id_d, pend_id_q;

  // No grants while in reset, so nothing reaches the memory.
  assign req_ok = bus.req_v_i & {num_req_p{~reset_i}};

  rr_arb #(.num_req_p(num_req_p), .id_w_lp(id_w_lp)) u_rr_arb (
    .req_i      (req_ok),
    .last_i     (last_q),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .grant_v_o  (grant_v)
  );

  // AND-OR style mux: with no grant the memory command collapses to all zero.
  always_comb begin
    sel_cmd = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant[k]) begin
        sel_cmd.w    = bus.req_w_i[k];
        sel_cmd.addr = bus.req_addr_i[k];
        sel_cmd.data = bus.req_data_i[k];
      end
    end
  end

  assign bus.req_yumi_o = grant;
  assign bus.mem_v_o    = grant_v;
  assign bus.mem_w_o    = sel_cmd.w;
  assign bus.mem_addr_o = sel_cmd.addr;
  assign bus.mem_data_o = sel_cmd.data;

  always_comb begin
    last_d    = grant_v ? grant_id : last_q;
    pend_v_d  = grant_v & ~sel_cmd.w;
    pend_id_d = grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q    <= id_w_lp'(num_req_p - 1);
      pend_v_q  <= 1'b0;
      pend_id_q <= '0;
    end else begin
      last_q    <= last_d;
      pend_v_q  <= pend_v_d;
      pend_id_q <= pend_id_d;
    end
  end

  // A read granted just before reset is squashed in the reset cycle itself;
  // pend_v_q is cleared by the same reset for the cycle after.
  always_comb begin
    bus.resp_v_o = '0;
    for (int k = 0; k < num_req_p; k++)
      bus.resp_v_o[k] = pend_v_q & ~reset_i & (pend_id_q == id_w_lp'(k));
  end

  assign bus.resp_data_o = bus.mem_data_i;
endmodule
